// File: rtl/ppumix.sv
// ppumix: final PPU pixel stage. Merges background and sprite pixels, resolves the
// sprite-0 hit, looks up the palette and serves $2007 palette access. Optional: PPUMIX_EMPH_EN.
module ppumix (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [8:0] ppux,
    input  logic [8:0] ppuy,
    input  logic       render,
    input  logic [7:0] ppumask,
    input  logic [3:0] bgpix,
    input  logic [3:0] sprpix,
    input  logic       sprpri,
    input  logic       spr0,
    input  logic [7:0] regwdata,
    input  logic       wr2007,
    input  logic       rd2007,
    input  logic       upalacc,
    input  logic [4:0] upaladdr,
    output logic [7:0] palrdata,
    output logic [5:0] color,
`ifdef PPUMIX_EMPH_EN
    output logic [2:0] emph,
`endif
    output logic [7:0] pixx,
    output logic [7:0] pixy,
    output logic       pixvalid,
    output logic       spr0hit
);

    // Entries 0x10/0x14/0x18/0x1C mirror the backdrop-class entries 0x00/0x04/0x08/0x0C.
    function automatic logic [4:0] pal_fold(input logic [4:0] addr);
        logic [4:0] folded;
        if (addr[4] && (addr[1:0] == 2'b00)) begin
            folded = {1'b0, addr[3:0]};
        end else begin
            folded = addr;
        end
        return folded;
    endfunction

    logic [5:0] r_pal [0:31];
    logic [7:0] r_palrdata;
    logic [5:0] r_color;
    logic [7:0] r_pixx;
    logic [7:0] r_pixy;
    logic       r_pixvalid;
    logic       r_spr0hit;

    logic       w_in_win;
    logic [8:0] w_x;
    logic       w_left;
    logic       w_bg_opq;
    logic       w_spr_opq;
    logic [4:0] w_index;
    logic [5:0] w_grey;
    logic [5:0] w_color;
    logic [5:0] w_cpu_data;
    logic       w_hit_set;
    logic       w_hit_clr;

    // Pixel merge, palette lookup and sprite-0 hit qualification for the current dot.
    always_comb begin
        w_in_win   = (ppux >= 9'd2) && (ppux <= 9'd257) && (ppuy <= 9'd239);
        w_x        = ppux - 9'd2;
        w_left     = (w_x < 9'd8);
        w_bg_opq   = (bgpix[1:0] != 2'b00) && ppumask[3] && !(w_left && !ppumask[1]);
        w_spr_opq  = (sprpix[1:0] != 2'b00) && ppumask[4] && !(w_left && !ppumask[2]);
        w_grey     = ppumask[0] ? 6'h30 : 6'h3F;
        w_index    = 5'd0;
        if (!render) begin
            // Backdrop override: with rendering off the CPU palette address picks the colour.
            if (upalacc) begin
                w_index = upaladdr;
            end else begin
                w_index = 5'd0;
            end
        end else if (w_spr_opq && (!sprpri || !w_bg_opq)) begin
            w_index = {1'b1, sprpix};
        end else if (w_bg_opq) begin
            w_index = {1'b0, bgpix};
        end else begin
            w_index = 5'd0;
        end
        w_color    = r_pal[pal_fold(w_index)] & w_grey;
        w_cpu_data = r_pal[pal_fold(upaladdr)] & w_grey;
        w_hit_set  = tick && w_in_win && render && spr0 && w_bg_opq && w_spr_opq
                     && (w_x[7:0] != 8'd255);
        w_hit_clr  = tick && (ppuy == 9'd261) && (ppux == 9'd1);
    end

    // Palette RAM: CPU writes only; contents survive reset.
    always_ff @(posedge clk) begin
        if (tick && wr2007 && upalacc) begin
            r_pal[pal_fold(upaladdr)] <= regwdata[5:0];
        end
    end

    // Registered pixel outputs, sprite-0 hit flag and $2007 read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_palrdata <= 8'h00;
            r_color    <= 6'h00;
            r_pixx     <= 8'h00;
            r_pixy     <= 8'h00;
            r_pixvalid <= 1'b0;
            r_spr0hit  <= 1'b0;
        end else if (tick) begin
            if (w_in_win) begin
                r_color    <= w_color;
                r_pixx     <= w_x[7:0];
                r_pixy     <= ppuy[7:0];
                r_pixvalid <= 1'b1;
            end else begin
                r_pixvalid <= 1'b0;
            end
            if (w_hit_clr) begin
                r_spr0hit <= 1'b0;
            end else if (w_hit_set) begin
                r_spr0hit <= 1'b1;
            end
            if (rd2007 && upalacc) begin
                r_palrdata <= {2'b00, w_cpu_data};
            end
        end
    end

`ifdef PPUMIX_EMPH_EN
    logic [2:0] r_emph;
    logic       w_unused;

    // Emphasis bits travel with the pixel they were sampled for.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_emph <= 3'b000;
        end else if (tick && w_in_win) begin
            r_emph <= ppumask[7:5];
        end
    end

    assign emph     = r_emph;
    assign w_unused = ^regwdata[7:6];
`else
    logic w_unused;
    assign w_unused = ^{ppumask[7:5], regwdata[7:6]};
`endif

    assign palrdata = r_palrdata;
    assign color    = r_color;
    assign pixx     = r_pixx;
    assign pixy     = r_pixy;
    assign pixvalid = r_pixvalid;
    assign spr0hit  = r_spr0hit;

endmodule

// File: tb/tb_ppumix.sv
// Self-checking bench for ppumix: directed scenarios plus randomized dots, all checked
// against a behavioural model of palette, priority and sprite-0 hit rules.
module tb_ppumix;

    logic       clk = 1'b0;
    logic       reset, tick, render, sprpri, spr0, wr2007, rd2007, upalacc;
    logic [8:0] ppux, ppuy;
    logic [7:0] ppumask, regwdata;
    logic [3:0] bgpix, sprpix;
    logic [4:0] upaladdr;
    logic [7:0] palrdata, pixx, pixy;
    logic [5:0] color;
    logic       pixvalid, spr0hit;
`ifdef PPUMIX_EMPH_EN
    logic [2:0] emph;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] m_pal [32];
    logic [7:0] e_rd;
    logic [5:0] e_color;
    logic [7:0] e_pixx, e_pixy;
    logic       e_pv, e_hit;
    logic [2:0] e_emph;

    always #5 clk = ~clk;

    ppumix dut (
        .clk(clk), .reset(reset), .tick(tick), .ppux(ppux), .ppuy(ppuy),
        .render(render), .ppumask(ppumask), .bgpix(bgpix), .sprpix(sprpix),
        .sprpri(sprpri), .spr0(spr0), .regwdata(regwdata), .wr2007(wr2007),
        .rd2007(rd2007), .upalacc(upalacc), .upaladdr(upaladdr),
        .palrdata(palrdata), .color(color),
`ifdef PPUMIX_EMPH_EN
        .emph(emph),
`endif
        .pixx(pixx), .pixy(pixy), .pixvalid(pixvalid), .spr0hit(spr0hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] m_fold(input logic [4:0] a);
        if (a == 5'h10 || a == 5'h14 || a == 5'h18 || a == 5'h1C) return a - 5'h10;
        return a;
    endfunction

    task automatic idle();
        reset = 1'b0; tick = 1'b1; render = 1'b1; sprpri = 1'b0; spr0 = 1'b0;
        wr2007 = 1'b0; rd2007 = 1'b0; upalacc = 1'b0; upaladdr = 5'd0;
        ppux = 9'd0; ppuy = 9'd250; ppumask = 8'h1E; regwdata = 8'h00;
        bgpix = 4'd0; sprpix = 4'd0;
    endtask

    // Predict the effect of one clock edge from the current inputs, then compare.
    task automatic cycle();
        int x;
        logic bo, so;
        logic [4:0] idx;
        logic [5:0] g;
        g = ppumask[0] ? 6'h30 : 6'h3F;
        if (reset) begin
            e_rd = 8'h00; e_color = 6'h00; e_pixx = 8'h00; e_pixy = 8'h00;
            e_pv = 1'b0; e_hit = 1'b0; e_emph = 3'b000;
        end else if (tick) begin
            if (ppux >= 2 && ppux <= 257 && ppuy <= 239) begin
                x  = int'(ppux) - 2;
                bo = (bgpix[1:0] != 0) && ppumask[3] && (x >= 8 || ppumask[1]);
                so = (sprpix[1:0] != 0) && ppumask[4] && (x >= 8 || ppumask[2]);
                if (!render) idx = upalacc ? upaladdr : 5'd0;
                else if (so && (!sprpri || !bo)) idx = {1'b1, sprpix};
                else if (bo) idx = {1'b0, bgpix};
                else idx = 5'd0;
                e_color = m_pal[m_fold(idx)] & g;
                e_pixx  = x[7:0];
                e_pixy  = ppuy[7:0];
                e_pv    = 1'b1;
                e_emph  = ppumask[7:5];
                if (render && spr0 && bo && so && x != 255) e_hit = 1'b1;
            end else begin
                e_pv = 1'b0;
            end
            if (ppuy == 261 && ppux == 1) e_hit = 1'b0;
            if (rd2007 && upalacc) e_rd = {2'b00, m_pal[m_fold(upaladdr)] & g};
        end
        if (tick && wr2007 && upalacc) m_pal[m_fold(upaladdr)] = regwdata[5:0];
        @(posedge clk);
        #1;
        check("color", 32'(color), 32'(e_color));
        check("pixx", 32'(pixx), 32'(e_pixx));
        check("pixy", 32'(pixy), 32'(e_pixy));
        check("pixvalid", 32'(pixvalid), 32'(e_pv));
        check("spr0hit", 32'(spr0hit), 32'(e_hit));
        check("palrdata", 32'(palrdata), 32'(e_rd));
`ifdef PPUMIX_EMPH_EN
        check("emph", 32'(emph), 32'(e_emph));
`endif
    endtask

    task automatic pal_write(input logic [4:0] a, input logic [7:0] d);
        idle(); wr2007 = 1'b1; upalacc = 1'b1; upaladdr = a; regwdata = d;
        cycle();
    endtask

    task automatic pal_read(input logic [4:0] a);
        idle(); rd2007 = 1'b1; upalacc = 1'b1; upaladdr = a; ppumask = 8'h00;
        cycle();
    endtask

    task automatic hit_clear();
        idle(); ppuy = 9'd261; ppux = 9'd1;
        cycle();
    endtask

    task automatic dot(input logic [8:0] px, input logic [8:0] py, input logic [7:0] m,
                       input logic [3:0] bg, input logic [3:0] sp, input logic pri, input logic s0);
        idle(); ppux = px; ppuy = py; ppumask = m; bgpix = bg; sprpix = sp; sprpri = pri; spr0 = s0;
        cycle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        check("rst_color", 32'(color), 32'h0);
        check("rst_spr0hit", 32'(spr0hit), 32'h0);

        for (int a = 0; a < 32; a++) pal_write(5'(a), 8'($urandom));

        // Mirroring
        pal_write(5'h10, 8'h2A);
        pal_read(5'h00);
        check("mirror_rd", 32'(palrdata), 32'h2A);
        pal_write(5'h01, 8'h0B);
        pal_write(5'h11, 8'h15);
        pal_read(5'h01);
        check("nomirror_rd", 32'(palrdata), 32'h0B);

        // Priority
        pal_write(5'h19, 8'h11);
        pal_write(5'h06, 8'h22);
        pal_write(5'h00, 8'h0F);
        dot(9'd100, 9'd50, 8'h1E, 4'b0110, 4'b1001, 1'b0, 1'b0);
        check("pri_spr_front", 32'(color), 32'h11);
        dot(9'd101, 9'd50, 8'h1E, 4'b0110, 4'b1001, 1'b1, 1'b0);
        check("pri_spr_behind", 32'(color), 32'h22);
        dot(9'd102, 9'd50, 8'h1E, 4'b0100, 4'b1001, 1'b1, 1'b0);
        check("pri_bg_transp", 32'(color), 32'h11);

        // Left clip and hit
        hit_clear();
        dot(9'd2, 9'd20, 8'h18, 4'b0110, 4'b1001, 1'b0, 1'b1);
        check("clip_color", 32'(color), 32'h0F);
        check("clip_nohit", 32'(spr0hit), 32'h0);
        dot(9'd10, 9'd20, 8'h18, 4'b0110, 4'b1001, 1'b1, 1'b1);
        check("hit_x8", 32'(spr0hit), 32'h1);
        dot(9'd100, 9'd240, 8'h1E, 4'b0110, 4'b1001, 1'b0, 1'b1);
        check("hit_hold_240", 32'(spr0hit), 32'h1);
        hit_clear();
        check("hit_clear", 32'(spr0hit), 32'h0);
        dot(9'd257, 9'd30, 8'h1E, 4'b0110, 4'b1001, 1'b0, 1'b1);
        check("hit_x255", 32'(spr0hit), 32'h0);
        check("x255_pixx", 32'(pixx), 32'hFF);

        // Greyscale backdrop and greyscale read
        pal_write(5'h05, 8'h27);
        idle(); render = 1'b0; upalacc = 1'b1; upaladdr = 5'h05; ppumask = 8'h01;
        ppux = 9'd50; ppuy = 9'd10; rd2007 = 1'b1;
        cycle();
        check("grey_color", 32'(color), 32'h20);
        check("grey_rd", 32'(palrdata), 32'h20);

        // Write and lookup of the same entry in one tick
        idle(); render = 1'b0; upalacc = 1'b1; upaladdr = 5'h07; wr2007 = 1'b1;
        regwdata = 8'h3C; ppux = 9'd60; ppuy = 9'd10;
        cycle();
        idle(); render = 1'b0; upalacc = 1'b1; upaladdr = 5'h07; ppux = 9'd61; ppuy = 9'd10;
        cycle();
        check("wr_then_lookup", 32'(color), 32'h3C);

        // Reset mid-frame
        dot(9'd40, 9'd100, 8'h1E, 4'b0110, 4'b1001, 1'b0, 1'b1);
        idle(); reset = 1'b1; ppux = 9'd50; ppuy = 9'd100; bgpix = 4'b0110;
        cycle();
        check("rst_mid_pv", 32'(pixvalid), 32'h0);
        check("rst_mid_hit", 32'(spr0hit), 32'h0);
        dot(9'd51, 9'd100, 8'h1E, 4'b0110, 4'b0000, 1'b0, 1'b0);
        check("resume_pv", 32'(pixvalid), 32'h1);

        // Randomized dots
        for (int i = 0; i < 3000; i++) begin
            idle();
            tick     = ($urandom_range(0, 9) < 8);
            render   = ($urandom_range(0, 9) < 8);
            ppumask  = 8'($urandom);
            bgpix    = 4'($urandom);
            sprpix   = 4'($urandom);
            sprpri   = 1'($urandom);
            spr0     = ($urandom_range(0, 3) == 0);
            upalacc  = ($urandom_range(0, 3) == 0);
            upaladdr = 5'($urandom);
            wr2007   = ($urandom_range(0, 7) == 0);
            rd2007   = ($urandom_range(0, 7) == 0);
            regwdata = 8'($urandom);
            ppux     = 9'($urandom_range(0, 340));
            ppuy     = ($urandom_range(0, 9) < 8) ? 9'($urandom_range(0, 239))
                                                  : 9'($urandom_range(240, 261));
            if ($urandom_range(0, 99) == 0) begin
                ppux = 9'd1; ppuy = 9'd261;
            end
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ppumix.md
# ppumix

Final PPU pixel stage, directly downstream of the background fetch/shift unit and the sprite unit. Each visible dot it merges the 4-bit background pixel with the sprite pixel under the priority rules and resolves the sprite-0 hit. It then looks the result up in the 32-entry palette RAM and emits a registered 6-bit colour index with screen coordinates to the video output. It also owns CPU access to the palette through $2007.

## Interface

Parameters: none.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  PPU dot enable; all state except reset advances only on clk edges with tick=1
- ppux  in  9  current dot, 0..340
- ppuy  in  9  current scanline, 0..261
- render  in  1  rendering active (PPUMASK bg|spr enabled and line in 0..239 or 261)
- ppumask  in  8  PPUMASK: [0] greyscale, [1] bg left-8 show, [2] spr left-8 show, [3] bg en, [4] spr en, [7:5] emphasis
- bgpix  in  4  {palette[1:0], pattern[1:0]} from background stage, valid for the current dot
- sprpix  in  4  {palette[1:0], pattern[1:0]} of the winning sprite
- sprpri  in  1  winning sprite is behind background
- spr0  in  1  winning sprite is OAM sprite 0
- regwdata  in  8  CPU write data
- wr2007  in  1  CPU $2007 write strobe, qualified by tick
- rd2007  in  1  CPU $2007 read strobe, qualified by tick
- upalacc  in  1  VRAM address v[13:8]==6'h3F
- upaladdr  in  5  v[4:0]
- palrdata  out  8  palette read data for $2007 reads: {2'b00, entry}
- color  out  6  palette colour index of the emitted pixel
- emph  out  3  emphasis bits of the emitted pixel (only with PPUMIX_EMPH_EN)
- pixx  out  8  x coordinate of the emitted pixel
- pixy  out  8  y coordinate of the emitted pixel
- pixvalid  out  1  color/pixx/pixy hold a visible pixel
- spr0hit  out  1  PPUSTATUS[6] sprite-0 hit flag

## Operation

- Palette RAM: 32 x 6 bits. Index folding: if addr[4] and addr[1:0]==0, clear addr[4]. This makes 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C for both read and write.
- CPU write: on tick && wr2007 && upalacc, pal[fold(upaladdr)] <= regwdata[5:0].
- CPU read: on tick && rd2007 && upalacc, palrdata <= {2'b00, pal[fold(upaladdr)] & (ppumask[0] ? 6'h30 : 6'h3F)}. palrdata is unchanged otherwise.
- Pixel window: dot ppux 2..257 on lines ppuy 0..239. Screen x = ppux-2.
- Clipping: bg is transparent if !ppumask[3], or if x<8 && !ppumask[1]. Sprite is transparent if !ppumask[4], or if x<8 && !ppumask[2].
- Opacity: a layer is opaque when its pix[1:0] != 0 and it is not clipped.
- Priority:
  - Sprite opaque and (!sprpri or bg transparent): index = {1'b1, sprpix}.
  - Otherwise, bg opaque: index = {1'b0, bgpix}.
  - Otherwise: index = 0.
- Rendering off (render=0): index = upalacc ? upaladdr : 0. This is the backdrop override.
- Colour: color = pal[fold(index)], ANDed with 6'h30 when ppumask[0] is set.
- Sprite-0 hit: set on a window tick when all of the following hold: render, spr0, both layers opaque after clipping, x != 255. The hit is independent of sprpri. Once set it stays set. It is cleared on the tick with ppuy==261 && ppux==1. It is not cleared by $2002 reads.

## Timing

- Reset values: color=0, emph=0, pixx=0, pixy=0, pixvalid=0, spr0hit=0, palrdata=0. Palette contents are not reset.
- On a window tick, color/emph/pixx/pixy are registered at that edge and pixvalid=1. The outputs hold until the next tick; latency is 1 clk from the tick.
- On a tick outside the window, pixvalid <= 0 and the other pixel outputs hold.
- A palette write and a pixel lookup of the same entry in the same tick: the pixel uses the old value. The new value is visible from the next tick.
- Simultaneous set and clear of spr0hit cannot occur, because the clear dot lies outside the window. If both are ever active, clear wins.
- Reset mid-line: outputs return to their reset values on that edge. Emission resumes at the next window tick.

## Configuration

- PPUMIX_EMPH_EN defined:
  - emph port is present.
  - emph <= ppumask[7:5] on each window tick, captured with the pixel.
- Not defined:
  - emph port is absent.
  - Emphasis bits are ignored.
  - No emph register is built.

## Test plan

- Palette mirroring: write 0x2A at upaladdr 0x10, then read upaladdr 0x00 -> palrdata=0x2A. Write 0x15 at 0x11, read 0x01 -> unchanged.
- Priority: bgpix=4'b0110, sprpix=4'b1001, sprpri=0 -> color=pal[0x19]. Same stimulus with sprpri=1 -> color=pal[0x06]. bgpix=4'b0100 with sprpri=1 -> color=pal[0x19].
- Left clip: ppux=2 (x=0), ppumask=0x18 (both left-8 flags clear), both layers opaque -> color=pal[0x00], spr0hit stays 0. Same stimulus at ppux=10 -> spr0hit=1.
- Hit edge and clear: opaque sprite 0 over opaque bg at ppux=257 (x=255) -> spr0hit stays 0. A hit at x=100 holds through line 240. Tick at ppuy=261, ppux=1 -> spr0hit=0.
- Greyscale and backdrop: render=0, upalacc=1, upaladdr=0x05, pal[5]=0x27, ppumask[0]=1 -> color=0x20. rd2007 with the same settings -> palrdata=0x20.
- Reset mid-frame at ppuy=100, ppux=50 -> next edge: pixvalid=0, color=0, spr0hit=0. Pixels resume at the next window tick.
